pipe_stage_skid: RTL

//  Parametrised, generic pipeline-stage register. It replaces the per-stage hand-written
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers. Adds a valid/ready handshake and a 2-entry

---
 rtl/pipe_stage_skid_pkg.sv | 24 ++
 rtl/pipe_data_reg.sv | 18 +
 rtl/pipe_stage_skid.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants and types for the pipeline-stage skid register.
// Stage payload widths live here so every stage instance sizes itself from one place.
// Optional perf counters in pipe_stage_skid are enabled by defining PIPE_STAGE_PERF_EN
// (left undefined by default).
package pipe_stage_skid_pkg;

  localparam int WIDTH        = 32;
  localparam int ADDR         = 32;
  localparam int WB_CTRL_SIZE = 4;

  // Concatenated stage-bus widths for each inter-stage register.
  localparam int IFID_DW  = WIDTH + ADDR;
  localparam int IDEX_DW  = WIDTH * 2 + ADDR + 16;
  localparam int EXMEM_DW = WIDTH * 2 + ADDR + WB_CTRL_SIZE + 4;
  localparam int MEMWB_DW = WIDTH * 2 + ADDR + WB_CTRL_SIZE;

  // Occupancy: EMPTY (no entry), ONE (main only), FULL (main + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_st_e;

endpackage

// File: rtl/pipe_data_reg.sv
// DW-wide payload register with load enable and synchronous clear (clear wins).
module pipe_data_reg #(
  parameter int DW = 64
) (
  input  logic          p_clk,
  input  logic          p_clr,
  input  logic          p_ld,
  input  logic [DW-1:0] p_d,
  output logic [DW-1:0] p_q
);

  // Clear has priority over load; otherwise hold.
  always_ff @(posedge p_clk) begin
    if (p_clr)     p_q <= '0;
    else if (p_ld) p_q <= p_d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// Back-pressure is registered: p_in_ready depends only on skid occupancy and hazard
// controls, never on p_out_ready.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/bubble counters; otherwise
// those ports are tied to 0 and no counter flops exist.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DW         = 64,
  parameter bit FLUSH_ZERO = 1'b1,
  parameter int CW         = 32
) (
  input  logic          p_clk,
  input  logic          p_reset,
  input  logic          p_in_valid,
  input  logic [DW-1:0] p_in_data,
  output logic          p_in_ready,
  output logic          p_out_valid,
  output logic [DW-1:0] p_out_data,
  input  logic          p_out_ready,
  input  logic          p_stall,
  input  logic          p_flush,
  output logic [CW-1:0] p_stall_cnt,
  output logic [CW-1:0] p_bubble_cnt
);

  skid_st_e      st, st_nxt;
  logic          main_v, skid_v;
  logic          acc, emit;
  logic          main_ld, main_from_skid, skid_ld, flush_clr;
  logic [DW-1:0] main_d, skid_d, main_in;

  // Valid bits derive from the state, so skid can never be valid without main.
  assign main_v = (st != ST_EMPTY);
  assign skid_v = (st == ST_FULL);

  // Reset gates the handshake so nothing is accepted or emitted while it is held.
  assign p_in_ready  = ~skid_v & ~p_stall & ~p_flush & ~p_reset;
  assign p_out_valid = main_v & ~p_stall & ~p_reset;
  assign p_out_data  = main_d;

  assign acc  = p_in_valid & p_in_ready;
  assign emit = p_out_valid & p_out_ready;

  // Occupancy register; reset returns to EMPTY.
  always_ff @(posedge p_clk) begin
    if (p_reset) st <= ST_EMPTY;
    else         st <= st_nxt;
  end

  // Next occupancy and entry load controls; flush overrides every handshake.
  always_comb begin
    st_nxt         = st;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    flush_clr      = 1'b0;
    if (p_flush) begin
      st_nxt    = ST_EMPTY;
      flush_clr = FLUSH_ZERO;
    end else begin
      unique case (st)
        ST_EMPTY: if (acc) begin
          st_nxt  = ST_ONE;
          main_ld = 1'b1;
        end
        ST_ONE: begin
          if (acc && emit)       main_ld = 1'b1;
          else if (acc)          begin st_nxt = ST_FULL; skid_ld = 1'b1; end
          else if (emit)         st_nxt = ST_EMPTY;
        end
        ST_FULL: if (emit) begin
          st_nxt         = ST_ONE;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
        default: st_nxt = ST_EMPTY;
      endcase
    end
  end

  assign main_in = main_from_skid ? skid_d : p_in_data;

  pipe_data_reg #(.DW(DW)) u_main (
    .p_clk (p_clk),
    .p_clr (p_reset | flush_clr),
    .p_ld  (main_ld),
    .p_d   (main_in),
    .p_q   (main_d)
  );

  pipe_data_reg #(.DW(DW)) u_skid (
    .p_clk (p_clk),
    .p_clr (p_reset | flush_clr),
    .p_ld  (skid_ld),
    .p_d   (p_in_data),
    .p_q   (skid_d)
  );

`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;

  // Saturating perf counters; only reset clears them, flush does not.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_v && (p_stall || !p_out_ready) && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (!p_out_valid && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign p_stall_cnt  = stall_cnt;
  assign p_bubble_cnt = bubble_cnt;
`else
  assign p_stall_cnt  = '0;
  assign p_bubble_cnt = '0;
`endif

endmodule
